// File: rtl/wait_pkg.sv
// Shared types and helpers for the wait-register FIFO.
package wait_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StHold  = 2'd1,
    StDrain = 2'd2
  } wait_state_e;

  // Bits needed to hold a count in the range 0..depth inclusive.
  function automatic int unsigned cnt_width(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/wait_regs_fifo_if.sv
// Producer/consumer bundle for wait_regs_fifo. master drives, slave is the FIFO.
interface wait_regs_fifo_if
  import wait_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic             enable;
  logic             delete;
  logic             pause;
  logic             save;
  logic             resume;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             overflow;

  modport master (
    output enable, delete, pause, save, resume, din, dout_ready,
    input  dout, dout_valid, count, full, empty, overflow
  );

  modport slave (
    input  enable, delete, pause, save, resume, din, dout_ready,
    output dout, dout_valid, count, full, empty, overflow
  );

endinterface

// File: rtl/wait_fifo_mem.sv
// Circular snapshot store: wrapping pointers, registered count/full/empty,
// data array without reset.
module wait_fifo_mem
  import wait_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q;
  logic             push_ok, pop_ok;

  function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push_ok = push & ~full_q;
  assign pop_ok  = pop & ~empty_q;

  // Next occupancy; full/empty are registered from it so they carry no input path.
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  // Snapshot storage, deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/wait_regs_fifo.sv
// Multi-entry wait register: captures snapshots while paused, replays them
// after resume over a valid/ready port with zeroed bubbles.
module wait_regs_fifo
  import wait_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input logic              clk,
  input logic              reset,
  wait_regs_fifo_if.slave  bus
);
  localparam int unsigned CW = cnt_width(DEPTH);

  wait_state_e      state_q, state_d;
  logic             overflow_q, overflow_d;
  logic             push, pop, flush;
  logic             dout_valid;
  logic [WIDTH-1:0] rdata;
  logic [CW-1:0]    count;
  logic             full, empty;

  wait_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .wdata (bus.din),
    .pop   (pop),
    .rdata (rdata),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Next state, FIFO commands and sticky overflow; all held while disabled.
  always_comb begin
    state_d    = state_q;
    overflow_d = overflow_q;
    push       = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;
    dout_valid = bus.enable && (state_q == StDrain) && !empty;
    if (bus.enable) begin
      if (bus.delete) begin
        flush      = 1'b1;
        state_d    = StIdle;
        overflow_d = 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (bus.pause) begin
              state_d = StHold;
              if (bus.save) begin
                if (full) overflow_d = 1'b1;
                else      push       = 1'b1;
              end
            end
          end
          StHold: begin
            if (bus.save) begin
              if (full) overflow_d = 1'b1;
              else      push       = 1'b1;
            end
            // A save on the resume edge counts toward whether there is anything to drain.
            if (bus.resume) begin
              state_d = (count != '0 || push) ? StDrain : StIdle;
            end
          end
          StDrain: begin
            pop = dout_valid && bus.dout_ready;
            if (pop && count == CW'(1)) begin
              state_d = bus.pause ? StHold : StIdle;
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  // State and overflow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.dout       = dout_valid ? rdata : '0;
  assign bus.dout_valid = dout_valid;
  assign bus.count      = count;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_wait_regs_fifo.sv
// Self-checking bench for wait_regs_fifo: behavioural model plus data scoreboard.
module tb_wait_regs_fifo;
  localparam int W = 32;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wait_regs_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();

  wait_regs_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: what the block is doing, how many it holds, and
  // the data it must replay, in order.
  typedef enum {MIdle, MCapture, MReplay} mode_e;
  mode_e      mode = MIdle;
  int         cnt  = 0;
  bit         ovf  = 1'b0;
  logic [W-1:0] exp_q[$];

  task automatic chk(string name, logic [63:0] got, logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic bit m_valid();
    return (mode == MReplay) && (bus.enable === 1'b1) && (cnt > 0);
  endfunction

  function automatic void m_clear();
    mode = MIdle;
    cnt  = 0;
    ovf  = 1'b0;
    exp_q.delete();
  endfunction

  function automatic void m_save();
    if (cnt < D) begin
      exp_q.push_back(bus.din);
      cnt++;
    end else begin
      ovf = 1'b1;
    end
  endfunction

  // Applied at each rising edge with the inputs that were present at that edge.
  function automatic void m_edge();
    if (reset) begin
      m_clear();
    end else if (!bus.enable) begin
      // frozen
    end else if (bus.delete) begin
      m_clear();
    end else begin
      case (mode)
        MIdle: if (bus.pause) begin
          mode = MCapture;
          if (bus.save) m_save();
        end
        MCapture: begin
          if (bus.save) m_save();
          if (bus.resume) mode = (cnt > 0) ? MReplay : MIdle;
        end
        MReplay: if (m_valid() && bus.dout_ready) begin
          cnt--;
          if (cnt == 0) mode = bus.pause ? MCapture : MIdle;
        end
        default: mode = MIdle;
      endcase
    end
  endfunction

  task automatic step(bit rst, bit en, bit del, bit pa, bit sa, bit re, bit rdy,
                      logic [W-1:0] d);
    reset          = rst;
    bus.enable     = en;
    bus.delete     = del;
    bus.pause      = pa;
    bus.save       = sa;
    bus.resume     = re;
    bus.dout_ready = rdy;
    bus.din        = d;
    @(posedge clk);
    m_edge();
    #1;
    chk("count", 64'(bus.count), 64'(cnt));
    chk("full", 64'(bus.full), 64'(cnt == D));
    chk("empty", 64'(bus.empty), 64'(cnt == 0));
    chk("overflow", 64'(bus.overflow), 64'(ovf));
  endtask

  task automatic idle(int n, bit rdy);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, rdy, '0);
  endtask

  // Monitor: on the falling edge compare presented data against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      chk("dout_valid", 64'(bus.dout_valid), 64'(m_valid()));
      if (bus.dout_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL dout: valid with nothing expected, got %0h at %0t", bus.dout, $time);
        end else begin
          chk("dout", 64'(bus.dout), 64'(exp_q[0]));
          if (bus.dout_ready && !bus.delete && !reset) void'(exp_q.pop_front());
        end
      end else begin
        chk("bubble", 64'(bus.dout), 64'd0);
      end
    end
  end

  initial begin
    step(1, 1, 0, 0, 0, 0, 0, '0);
    step(1, 1, 0, 0, 0, 0, 0, '0);

    // Three captures replayed in order.
    step(0, 1, 0, 1, 0, 0, 1, '0);
    step(0, 1, 0, 0, 1, 0, 1, 32'hA);
    step(0, 1, 0, 0, 1, 0, 1, 32'hB);
    step(0, 1, 0, 0, 1, 0, 1, 32'hC);
    step(0, 1, 0, 0, 0, 1, 1, '0);
    idle(5, 1);

    // Overfill: six saves into four slots.
    step(0, 1, 0, 1, 0, 0, 1, '0);
    for (int i = 1; i <= 6; i++) step(0, 1, 0, 0, 1, 0, 1, W'(i));
    step(0, 1, 0, 0, 0, 1, 1, '0);
    idle(6, 1);

    // Delete in capture with two held and overflow still set.
    step(0, 1, 0, 1, 0, 0, 1, '0);
    step(0, 1, 0, 0, 1, 0, 1, 32'h21);
    step(0, 1, 0, 0, 1, 0, 1, 32'h22);
    step(0, 1, 1, 0, 0, 0, 1, '0);
    idle(2, 1);

    // Backpressure: data must hold while ready is low.
    step(0, 1, 0, 1, 0, 0, 0, '0);
    step(0, 1, 0, 0, 1, 0, 0, 32'h11);
    step(0, 1, 0, 0, 1, 0, 0, 32'h22);
    step(0, 1, 0, 0, 0, 1, 0, '0);
    idle(3, 0);
    idle(3, 1);

    // Disable mid-replay, then continue from the same entry.
    step(0, 1, 0, 1, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1, 0, 0, W'(32'h30 + i));
    step(0, 1, 0, 0, 0, 1, 1, '0);
    step(0, 1, 0, 0, 0, 0, 1, '0);
    step(0, 0, 0, 0, 0, 0, 1, '0);
    step(0, 0, 0, 0, 0, 0, 1, '0);
    idle(4, 1);

    // Reset mid-replay with three entries.
    step(0, 1, 0, 1, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1, 0, 0, W'(32'h40 + i));
    step(0, 1, 0, 0, 0, 1, 0, '0);
    step(1, 1, 0, 0, 0, 0, 0, '0);
    idle(2, 1);

    // Pause then resume with nothing saved.
    step(0, 1, 0, 1, 0, 0, 1, '0);
    step(0, 1, 0, 0, 0, 1, 1, '0);
    idle(3, 1);

    // Legacy mode: pause/save/resume every cycle, consumer always ready.
    for (int i = 0; i < 12; i++) step(0, 1, 0, 1, 1, 1, 1, W'(100 + i));
    idle(3, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 9) < 2),
           ($urandom_range(0, 9) < 7),
           W'($urandom));
    end
    idle(8, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
